// File: rtl/neopixel_chain_ctrl_if.sv
// Load/trigger/status bundle between the byte source and the WS2812 chain controller.
interface neopixel_chain_ctrl_if;
    logic [7:0] i_byte;
    logic       i_valid;
    logic       i_sof;
    logic       i_trigger;
    logic       o_dout;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_load_done;

    modport master (
        output i_byte, i_valid, i_sof, i_trigger,
        input  o_dout, o_busy, o_frame_done, o_load_done
    );

    modport slave (
        input  i_byte, i_valid, i_sof, i_trigger,
        output o_dout, o_busy, o_frame_done, o_load_done
    );
endinterface

// File: rtl/neopixel_chain_ctrl.sv
// WS2812 chain controller: double-buffered GRB byte store loaded from a byte
// stream, tear-free bank swap in IDLE, and a serial bit-timing encoder.
module neopixel_chain_ctrl #(
    parameter int NUM_PIXELS   = 10,
    parameter int TBIT         = 15,
    parameter int T0H          = 4,
    parameter int T1H          = 9,
    parameter int TRESET       = 600,
    parameter int AUTO_REFRESH = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    neopixel_chain_ctrl_if.slave bus
);
    localparam int NB     = 3 * NUM_PIXELS;
    localparam int PTR_W  = $clog2(NB);
    localparam int AW     = $clog2(2 * NB);
    localparam int TC_MAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int TC_W   = $clog2(TC_MAX);
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_BIT_HIGH, ST_BIT_LOW, ST_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               front_q, front_d;
    logic               commit_pending_q, commit_pending_d;
    logic               have_frame_q, have_frame_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [TC_W-1:0]    tcnt_q, tcnt_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               load_done_q, load_done_d;

    logic               we_s;
    logic               swap_s;
    logic [PTR_W-1:0]   widx_s;
    logic [AW-1:0]      wr_addr_s;
    logic [AW-1:0]      rd_addr_s;
    logic [1:0]         rd_off_s;
    logic [TC_W-1:0]    hi_last_s;

    logic [7:0]         mem_q [0:2*NB-1];
    logic [7:0]         rd_data_q;

    // Byte loader: pointer update, back-bank write enable, full-load detection.
    always_comb begin
        ptr_d  = ptr_q;
        we_s   = 1'b0;
        widx_s = '0;
        if (bus.i_valid) begin
            if (bus.i_sof) begin
                we_s   = 1'b1;
                widx_s = '0;
                ptr_d  = PTR_W'(32'd1);
            end else if (ptr_q < PTR_W'(NB)) begin
                we_s   = 1'b1;
                widx_s = ptr_q;
                ptr_d  = ptr_q + PTR_W'(32'd1);
            end else begin
                ptr_d  = ptr_q;
            end
        end else if (bus.i_sof) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q;
        end
        load_done_d = we_s && (widx_s == PTR_W'(NB - 1));
        // The back bank is whichever bank is not being transmitted.
        wr_addr_s   = AW'(32'(widx_s) + (front_q ? 32'd0 : 32'(NB)));
    end

    // Bank swap: only while idle and with no byte arriving in the same cycle.
    always_comb begin
        swap_s           = (state_q == ST_IDLE) && commit_pending_q && !bus.i_valid;
        front_d          = swap_s ? ~front_q : front_q;
        commit_pending_d = load_done_d | (commit_pending_q & ~swap_s);
        have_frame_d     = have_frame_q | swap_s;
    end

    // Frame sequencer: pixel fetch, per-bit high/low timing, latch period.
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        bit_cnt_d = bit_cnt_q;
        tcnt_d    = tcnt_q;
        shreg_d   = shreg_q;
        rd_off_s  = 2'd0;
        hi_last_s = shreg_q[23] ? TC_W'(T1H - 1) : TC_W'(T0H - 1);
        case (state_q)
            ST_IDLE: begin
                if (have_frame_q && ((AUTO_REFRESH != 0) || bus.i_trigger)) begin
                    state_d   = ST_FETCH;
                    pix_d     = '0;
                    bit_cnt_d = 5'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Addresses issued on counts 0..2, data captured on counts 1..3.
                rd_off_s = (bit_cnt_q[1:0] == 2'd3) ? 2'd0 : bit_cnt_q[1:0];
                if (bit_cnt_q != 5'd0) begin
                    shreg_d = {shreg_q[15:0], rd_data_q};
                end else begin
                    shreg_d = shreg_q;
                end
                if (bit_cnt_q == 5'd3) begin
                    state_d   = ST_BIT_HIGH;
                    bit_cnt_d = 5'd0;
                    tcnt_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_BIT_HIGH: begin
                tcnt_d = tcnt_q + TC_W'(32'd1);
                if (tcnt_q == hi_last_s) begin
                    state_d = ST_BIT_LOW;
                end else begin
                    state_d = ST_BIT_HIGH;
                end
            end
            ST_BIT_LOW: begin
                if (tcnt_q == TC_W'(TBIT - 1)) begin
                    tcnt_d  = '0;
                    shreg_d = {shreg_q[22:0], 1'b0};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        if (pix_q == PIX_W'(NUM_PIXELS - 1)) begin
                            state_d = ST_LATCH;
                        end else begin
                            pix_d   = pix_q + PIX_W'(32'd1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = ST_BIT_HIGH;
                    end
                end else begin
                    tcnt_d = tcnt_q + TC_W'(32'd1);
                end
            end
            ST_LATCH: begin
                if (tcnt_q == TC_W'(TRESET - 1)) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d  = tcnt_q + TC_W'(32'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_addr_s    = AW'(32'(pix_q) * 32'd3 + 32'(rd_off_s) + (front_q ? 32'(NB) : 32'd0));
        // Outputs are decoded from the next state so they register in step with it.
        dout_d       = (state_d == ST_BIT_HIGH);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_LATCH) && (tcnt_d == TC_W'(TRESET - 1));
    end

    // Pixel RAM: back-bank writes and registered front-bank reads.
    always_ff @(posedge CLK) begin
        if (we_s) begin
            mem_q[wr_addr_s] <= bus.i_byte;
        end
        rd_data_q <= mem_q[rd_addr_s];
    end

    // Control and output registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q          <= ST_IDLE;
            ptr_q            <= '0;
            front_q          <= 1'b0;
            commit_pending_q <= 1'b0;
            have_frame_q     <= 1'b0;
            pix_q            <= '0;
            bit_cnt_q        <= 5'd0;
            tcnt_q           <= '0;
            shreg_q          <= 24'd0;
            dout_q           <= 1'b0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
            load_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            front_q          <= front_d;
            commit_pending_q <= commit_pending_d;
            have_frame_q     <= have_frame_d;
            pix_q            <= pix_d;
            bit_cnt_q        <= bit_cnt_d;
            tcnt_q           <= tcnt_d;
            shreg_q          <= shreg_d;
            dout_q           <= dout_d;
            busy_q           <= busy_d;
            frame_done_q     <= frame_done_d;
            load_done_q      <= load_done_d;
        end
    end

    assign bus.o_dout       = dout_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_load_done  = load_done_q;
endmodule

// File: tb/tb_neopixel_chain_ctrl.sv
// Bench: two controllers (2 pixels triggered, 1 pixel auto-refresh). A monitor
// decodes the serial line back into frames and compares them with a scoreboard
// fed by a byte-level model of the load/commit rules.
module tb_neopixel_chain_ctrl;
    localparam int TBIT = 15, T0H = 4, T1H = 9, TRESET = 600;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    neopixel_chain_ctrl_if bus_a ();
    neopixel_chain_ctrl_if bus_b ();

    neopixel_chain_ctrl #(.NUM_PIXELS(2), .TBIT(TBIT), .T0H(T0H), .T1H(T1H),
                          .TRESET(TRESET), .AUTO_REFRESH(0))
        u_dut_a (.CLK(CLK), .RSTN(RSTN), .bus(bus_a));
    neopixel_chain_ctrl #(.NUM_PIXELS(1), .TBIT(TBIT), .T0H(T0H), .T1H(T1H),
                          .TRESET(TRESET), .AUTO_REFRESH(1))
        u_dut_b (.CLK(CLK), .RSTN(RSTN), .bus(bus_b));

    typedef struct packed { int k; logic [47:0] pat; } chg_t;

    int tests = 0, fails = 0;

    // Scoreboards
    logic [47:0] exp_a[$];   // frames expected from A, in order
    chg_t        exp_b[$];   // B pattern valid from frame index k onward
    int          b_next_k;

    // Reference model of the byte store
    logic [7:0]  m_buf [2][6];
    int          m_ptr [2] = '{0, 0};
    bit          m_have[2] = '{0, 0};
    int          ld_exp[2] = '{0, 0};
    logic [47:0] committed_a = '0;
    int          npix  [2] = '{2, 1};

    // Monitor state
    logic        prev_d[2] = '{0, 0};
    logic        prev_bsy[2] = '{0, 0};
    int          hi_c[2] = '{0, 0}, lo_c[2] = '{0, 0}, last_hi[2] = '{0, 0};
    int          nbits[2] = '{0, 0}, frames[2] = '{0, 0}, ld_cnt[2] = '{0, 0};
    int          busy_cnt[2] = '{0, 0}, idle_run[2] = '{0, 0};
    bit          gap_ok[2] = '{0, 0};
    logic [47:0] fbits[2] = '{48'd0, 48'd0};

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Serial decoder and frame scoreboard, sampled on the falling clock edge.
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            logic dout, bsy, fd, ld, bitv;
            dout = (d == 0) ? bus_a.o_dout       : bus_b.o_dout;
            bsy  = (d == 0) ? bus_a.o_busy       : bus_b.o_busy;
            fd   = (d == 0) ? bus_a.o_frame_done : bus_b.o_frame_done;
            ld   = (d == 0) ? bus_a.o_load_done  : bus_b.o_load_done;
            if (!RSTN) begin
                prev_d[d] = 1'b0; prev_bsy[d] = 1'b0; hi_c[d] = 0; lo_c[d] = 0;
                nbits[d] = 0; fbits[d] = '0; gap_ok[d] = 1'b0; idle_run[d] = 0;
            end else begin
                if (bsy) busy_cnt[d]++;
                else     idle_run[d]++;
                if (ld) ld_cnt[d]++;
                if (dout) check($sformatf("busy_with_dout%0d", d), bsy, 1);
                if (bsy && !prev_bsy[d] && gap_ok[d]) begin
                    if (d == 1) check_range("auto_gap", idle_run[d], 0, 2);
                    gap_ok[d] = 1'b0;
                end
                if (dout) begin
                    if (!prev_d[d]) begin
                        if (nbits[d] > 0) begin
                            if (nbits[d] % 24 != 0)
                                check($sformatf("bit_period%0d", d), last_hi[d] + lo_c[d], TBIT);
                            else
                                check_range($sformatf("pixel_gap%0d", d), lo_c[d],
                                            TBIT - last_hi[d], TBIT - last_hi[d] + 4);
                        end
                        hi_c[d] = 1;
                    end else begin
                        hi_c[d]++;
                    end
                end else begin
                    if (prev_d[d]) begin
                        tests++;
                        if (hi_c[d] == T1H) bitv = 1'b1;
                        else begin
                            bitv = 1'b0;
                            if (hi_c[d] != T0H) begin
                                fails++;
                                $display("FAIL high_width%0d: got %0d cycles expected %0d or %0d",
                                         d, hi_c[d], T0H, T1H);
                            end
                        end
                        fbits[d]   = {fbits[d][46:0], bitv};
                        nbits[d]++;
                        last_hi[d] = hi_c[d];
                        lo_c[d]    = 1;
                    end else begin
                        lo_c[d]++;
                    end
                end
                prev_d[d]   = dout;
                prev_bsy[d] = bsy;
                if (fd) begin
                    check($sformatf("frame_bits%0d", d), nbits[d], 24 * npix[d]);
                    check($sformatf("latch_low%0d", d), lo_c[d], TBIT - last_hi[d] + TRESET);
                    if (d == 0) begin
                        if (exp_a.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_frame_a: got 0x%0h expected none", fbits[0]);
                        end else begin
                            check("frame_a", fbits[0], exp_a.pop_front());
                        end
                    end else begin
                        while (exp_b.size() > 1 && exp_b[1].k <= frames[1]) void'(exp_b.pop_front());
                        if (exp_b.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_frame_b: got 0x%0h expected none", fbits[1]);
                        end else begin
                            check("frame_b", fbits[1][23:0], exp_b[0].pat);
                        end
                    end
                    frames[d]++;
                    nbits[d] = 0; fbits[d] = '0; gap_ok[d] = 1'b1; idle_run[d] = 0;
                end
            end
        end
    end

    // Byte-level load model: pointer, drop-at-full, completion snapshot.
    task automatic model_step(input int d, input logic v, input logic s, input logic [7:0] b);
        int nb, idx;
        logic [47:0] pat;
        nb = 3 * npix[d];
        if (v) begin
            idx = s ? 0 : m_ptr[d];
            if (idx < nb) begin
                m_buf[d][idx] = b;
                m_ptr[d] = idx + 1;
                if (idx == nb - 1) begin
                    pat = '0;
                    for (int i = 0; i < nb; i++) pat = {pat[39:0], m_buf[d][i]};
                    ld_exp[d]++;
                    m_have[d] = 1'b1;
                    if (d == 0) committed_a = pat;
                    else exp_b.push_back('{b_next_k, pat});
                end
            end
        end else if (s) begin
            m_ptr[d] = 0;
        end
    endtask

    task automatic drive(input int d, input logic v, input logic s, input logic t, input logic [7:0] b);
        @(posedge CLK); #1;
        if (d == 0) begin
            bus_a.i_valid = v; bus_a.i_sof = s; bus_a.i_trigger = t; bus_a.i_byte = b;
        end else begin
            bus_b.i_valid = v; bus_b.i_sof = s; bus_b.i_trigger = t; bus_b.i_byte = b;
        end
        model_step(d, v, s, b);
    endtask

    task automatic load(input int d, input int n, input logic [7:0] bytes [8], input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
            drive(d, 1'b1, (i == 0), 1'b0, bytes[i]);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
        check($sformatf("load_done_count%0d", d), ld_cnt[d], ld_exp[d]);
    endtask

    task automatic wait_idle_a();
        int c = 0;
        while (bus_a.o_busy && c < 3000) begin @(posedge CLK); #1; c++; end
        check("wait_idle_a", bus_a.o_busy, 0);
    endtask

    task automatic trigger_a();
        wait_idle_a();
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
        if (m_have[0]) exp_a.push_back(committed_a);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_frames(input int d, input int target, input int budget);
        int c = 0;
        while (frames[d] < target && c < budget) begin @(posedge CLK); c++; end
        tests++;
        if (frames[d] < target) begin
            fails++;
            $display("FAIL wait_frame%0d: got %0d frames expected %0d", d, frames[d], target);
        end
    endtask

    task automatic rand_bytes(output logic [7:0] bytes [8]);
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [7:0] bv [8];
        int base_a, base_b, fr, c;

        bus_a.i_valid = 1'b0; bus_a.i_sof = 1'b0; bus_a.i_trigger = 1'b0; bus_a.i_byte = 8'h00;
        bus_b.i_valid = 1'b0; bus_b.i_sof = 1'b0; bus_b.i_trigger = 1'b0; bus_b.i_byte = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_dout_a", bus_a.o_dout, 0);       check("rst_busy_a", bus_a.o_busy, 0);
        check("rst_fdone_a", bus_a.o_frame_done, 0); check("rst_ldone_a", bus_a.o_load_done, 0);
        check("rst_dout_b", bus_b.o_dout, 0);       check("rst_busy_b", bus_b.o_busy, 0);
        RSTN = 1'b1;

        // Trigger with nothing loaded: no activity.
        base_a = busy_cnt[0]; fr = frames[0];
        trigger_a();
        repeat (50) @(posedge CLK);
        check("no_frame_busy", busy_cnt[0] - base_a, 0);
        check("no_frame_frames", frames[0], fr);

        // Directed load and triggered frame.
        bv = '{8'h80, 8'h01, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h00, 8'h00};
        load(0, 6, bv, 1'b0);
        trigger_a();
        wait_frames(0, fr + 1, 3000);

        // Auto-refresh chain with a single '1' as the very last bit.
        b_next_k = frames[1];
        bv = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(1, 3, bv, 1'b0);
        wait_frames(1, frames[1] + 3, 4000);

        // Reload B mid-frame: current frame keeps the old pattern, the next shows the new.
        for (int it = 0; it < 3; it++) begin
            c = 0;
            while (!(bus_b.o_busy && nbits[1] >= 2 && nbits[1] <= 12) && c < 3000) begin
                @(negedge CLK); c++;
            end
            check("wait_midframe_b", (nbits[1] >= 2 && nbits[1] <= 12), 1);
            b_next_k = frames[1] + 1;
            rand_bytes(bv);
            load(1, 3, bv, 1'b0);
            wait_frames(1, b_next_k + 2, 4000);
        end

        // Random full loads on A with idle gaps between bytes.
        for (int it = 0; it < 4; it++) begin
            rand_bytes(bv);
            fr = frames[0];
            load(0, 6, bv, 1'b1);
            trigger_a();
            wait_frames(0, fr + 1, 3000);
        end

        // Overflow: bytes 7 and 8 dropped, frame is the first six.
        rand_bytes(bv);
        fr = frames[0];
        load(0, 8, bv, 1'b0);
        trigger_a();
        wait_frames(0, fr + 1, 3000);
        // i_sof together with i_valid puts 0x55 at index 0.
        rand_bytes(bv);
        bv[0] = 8'h55;
        load(0, 6, bv, 1'b0);
        trigger_a();
        wait_frames(0, fr + 2, 3000);

        // Asynchronous reset while A drives a high pulse.
        trigger_a();
        c = 0;
        while (!bus_a.o_dout && c < 3000) begin @(negedge CLK); c++; end
        check("wait_high_a", bus_a.o_dout, 1);
        #2;
        RSTN = 1'b0;
        #1;
        check("rst_async_dout_a", bus_a.o_dout, 0);
        check("rst_async_busy_a", bus_a.o_busy, 0);
        m_ptr = '{0, 0}; m_have = '{0, 0};
        exp_a.delete(); exp_b.delete();
        repeat (3) @(negedge CLK);
        #1;
        RSTN = 1'b1;
        base_a = busy_cnt[0]; base_b = busy_cnt[1]; fr = frames[0];
        trigger_a();
        repeat (100) @(posedge CLK);
        check("post_rst_idle_a", busy_cnt[0] - base_a, 0);
        check("post_rst_idle_b", busy_cnt[1] - base_b, 0);
        check("post_rst_frames_a", frames[0], fr);

        // Fresh loads after reset bring both chains back.
        rand_bytes(bv);
        load(0, 6, bv, 1'b1);
        trigger_a();
        wait_frames(0, fr + 1, 3000);
        b_next_k = frames[1];
        rand_bytes(bv);
        load(1, 3, bv, 1'b0);
        wait_frames(1, frames[1] + 2, 4000);

        wait_idle_a();
        check("exp_a_drained", exp_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
